// File: rtl/seg_pkg.sv
// Shared seven-segment constants, digit pattern table and converter state type.
// Latency: none, pure constants and a combinational lookup.
// Backpressure: not applicable.
package seg_pkg;

    // Internal patterns are active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    // Entry d holds the pattern for decimal digit d
    localparam logic [9:0][6:0] DIGIT_SEG = {
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Non-decimal codes never come out of the converter; show them blank just in case
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return DIGIT_SEG[d];
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one add-3-then-shift step per clk over a 4*NUM_DIGITS BCD register.
// Latency: start accepted on one edge, VAL_W shift edges follow; bcd is final after the edge where done is high.
// Backpressure: start is ignored while busy; bcd holds its final value until the next start.
module bin_to_bcd_seq #(
    parameter int VAL_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    start,
    input  logic [VAL_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] bin_sr;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] bcd_adj;

    // Add 3 to every BCD digit that is 5 or more before the next shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // High during the final shift cycle, so the caller can move on in step with it
    assign done = busy && (cnt == '0);

    // Load on start, then shift the binary MSB into the adjusted BCD register VAL_W times
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (busy) begin
            bcd    <= BCD_W'({bcd_adj, bin_sr[VAL_W-1]});
            bin_sr <= bin_sr << 1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (start) begin
            bin_sr <= bin;
            bcd    <= '0;
            cnt    <= CNT_W'(VAL_W - 1);
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// N-digit multiplexed seven-segment driver: binary value -> BCD -> scanned digit pins.
// Latency: value change to committed digits VAL_W+2 clk; pins refresh on the next clk_display tick.
// Backpressure: value changes while busy are held off and reconverted once idle; last value always wins.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int VAL_W          = 14,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  clk_display,
    input  logic [VAL_W-1:0]      value,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int                    BCD_W     = 4 * NUM_DIGITS;
    localparam int                    IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0]           OVF_LIMIT = 32'(10 ** NUM_DIGITS);
    localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    conv_state_t                    state;
    logic [VAL_W-1:0]               last_val;
    logic                           ovf_pend;
    logic [BCD_W-1:0]               disp_bcd;
    logic                           disp_ovf;
    logic                           start;
    logic                           conv_busy;
    logic                           conv_done;
    logic [BCD_W-1:0]               conv_bcd;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               next_idx;
    logic [NUM_DIGITS-1:0][6:0]     pat;
    logic                           lead_zero;
    logic [NUM_DIGITS-1:0]          an_onehot;

    assign start = (state == ST_IDLE) && !conv_busy && (value != last_val);

    bin_to_bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .arst  (arst),
        .start (start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Converter control: sample on change, wait for the shifter, then update all digits on one edge
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_IDLE;
            last_val <= '0;
            ovf_pend <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last_val <= value;
                        ovf_pend <= (32'(value) >= OVF_LIMIT);
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (conv_done) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_bcd <= conv_bcd;
                    disp_ovf <= ovf_pend;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign overflow = disp_ovf;

    // Per-digit active-high pattern: dashes on overflow, else digits with optional leading-zero blanking
    always_comb begin
        pat       = '0;
        lead_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead_zero = lead_zero && (disp_bcd[4*k +: 4] == 4'd0);
            if (disp_ovf) begin
                pat[k] = SEG_DASH;
            end else if ((BLANK_LEADING != 0) && (k != 0) && lead_zero) begin
                pat[k] = SEG_BLANK;
            end else begin
                pat[k] = digit_to_seg(disp_bcd[4*k +: 4]);
            end
        end
    end

    assign next_idx  = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    assign an_onehot = NUM_DIGITS'(1) << next_idx;

    // Scan: on each refresh tick move to the next digit and drive its anode and segments together
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx <= '0;
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (clk_display) begin
            idx <= next_idx;
            an  <= (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
            seg <= (SEG_ACTIVE_LOW != 0) ? ~pat[next_idx] : pat[next_idx];
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: two instances (active-low with blanking, active-high without) share stimulus.
// Expected pins/flags are queued per clock from a decimal-arithmetic model and popped by a monitor.
// Directed scenarios first, then randomized values, tick patterns and reset pulses.
module tb_seg_display_mux;

    logic        clk = 1'b0;
    logic        arst;
    logic        clk_display;
    logic [13:0] value;

    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;

    always #5 clk = ~clk;

    seg_display_mux #(
        .NUM_DIGITS(4), .VAL_W(14), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .arst(arst), .clk_display(clk_display), .value(value),
        .busy(busy_a), .overflow(ovf_a), .an(an_a), .seg(seg_a)
    );

    seg_display_mux #(
        .NUM_DIGITS(4), .VAL_W(14), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LEADING(0)
    ) dut_b (
        .clk(clk), .arst(arst), .clk_display(clk_display), .value(value),
        .busy(busy_b), .overflow(ovf_b), .an(an_b), .seg(seg_b)
    );

    typedef struct {
        logic       busy;
        logic       ovf;
        logic [3:0] an_a;
        logic [6:0] seg_a;
        logic [3:0] an_b;
        logic [6:0] seg_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: plain decimal numbers and a countdown of remaining busy cycles
    int         m_last, m_comm, m_cnt, m_idx;
    logic [3:0] m_an_a, m_an_b;
    logic [6:0] m_seg_a, m_seg_b;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] ref_seg(int val, int k, bit blank_lead, bit act_low);
        logic [6:0] p;
        int pw = 1;
        for (int i = 0; i < k; i++) pw = pw * 10;
        if (val >= 10000)                          p = 7'h40;
        else if (blank_lead && k > 0 && val < pw)  p = 7'h00;
        else                                       p = seg_tbl[(val / pw) % 10];
        return act_low ? ~p : p;
    endfunction

    function automatic logic [3:0] ref_an(int k, bit act_low);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        return act_low ? ~oh : oh;
    endfunction

    task automatic model_reset();
        m_last  = 0;
        m_comm  = 0;
        m_cnt   = 0;
        m_idx   = 0;
        m_an_a  = 4'hF;
        m_seg_a = 7'h7F;
        m_an_b  = 4'h0;
        m_seg_b = 7'h00;
    endtask

    // Advance the model across one clock edge using the inputs currently applied
    task automatic model_edge();
        if (arst) begin
            model_reset();
        end else begin
            if (clk_display) begin
                m_idx   = (m_idx + 1) % 4;
                m_an_a  = ref_an(m_idx, 1'b1);
                m_seg_a = ref_seg(m_comm, m_idx, 1'b1, 1'b1);
                m_an_b  = ref_an(m_idx, 1'b0);
                m_seg_b = ref_seg(m_comm, m_idx, 1'b0, 1'b0);
            end
            if (m_cnt == 0) begin
                if (int'(value) != m_last) begin
                    m_last = int'(value);
                    m_cnt  = 15;
                end
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_comm = m_last;
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.busy  = (m_cnt > 0);
        e.ovf   = (m_comm >= 10000);
        e.an_a  = m_an_a;
        e.seg_a = m_seg_a;
        e.an_b  = m_an_b;
        e.seg_b = m_seg_b;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, value=%0d)", nm, act, exp, $time, value);
        end
    endtask

    // One clock: apply tick, predict, queue the expected post-edge outputs
    task automatic cyc(bit tick);
        clk_display = tick;
        model_edge();
        @(posedge clk);
        sb_q.push_back(snap());
        #1;
        clk_display = 1'b0;
    endtask

    task automatic run(int n, int tick_pct);
        for (int i = 0; i < n; i++) cyc($urandom_range(0, 99) < tick_pct);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    // Async assert mid-cycle: the expectation for this cycle becomes the reset state
    task automatic assert_reset();
        arst = 1'b1;
        model_reset();
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        sb_q.push_back(snap());
    endtask

    // Monitor: compare every queued expectation against both instances away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("busy_a",     32'(busy_a), 32'(e.busy));
            chk("overflow_a", 32'(ovf_a),  32'(e.ovf));
            chk("an_a",       32'(an_a),   32'(e.an_a));
            chk("seg_a",      32'(seg_a),  32'(e.seg_a));
            chk("busy_b",     32'(busy_b), 32'(e.busy));
            chk("overflow_b", 32'(ovf_b),  32'(e.ovf));
            chk("an_b",       32'(an_b),   32'(e.an_b));
            chk("seg_b",      32'(seg_b),  32'(e.seg_b));
        end
    end

    initial begin
        arst        = 1'b1;
        clk_display = 1'b0;
        value       = '0;
        model_reset();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        arst = 1'b0;

        // Value 0 scan: digit 0 shows "0", others blank on the blanking instance
        ticks(8);

        // Plain conversion and full scan
        value = 14'd1234;
        run(20, 0);
        ticks(8);

        // Largest in-range value, then first overflowing value
        value = 14'd9999;
        run(17, 0);
        ticks(4);
        value = 14'd10000;
        run(17, 0);
        ticks(4);

        // Changes while busy: last value must win, display never shows a partial update
        value = 14'd5;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        value = 14'd7;
        run(4, 50);
        value = 14'd1050;
        run(40, 50);

        // Embedded zeros and blanking differences
        value = 14'd1234;
        run(17, 30);
        value = 14'd1200;
        run(17, 0);
        ticks(4);
        value = 14'd42;
        run(17, 0);
        ticks(4);

        // Reset in the middle of a shift, then reconversion of the held value
        value = 14'd3000;
        run(6, 0);
        value = 14'd77;
        assert_reset();
        cyc(1'b1);
        cyc(1'b1);
        arst = 1'b0;
        run(17, 0);
        ticks(4);

        // Randomized values, tick density and occasional reset pulses
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0: value = 14'($urandom_range(0, 16383));
                1: value = 14'($urandom_range(9990, 10010));
                2: value = 14'($urandom_range(0, 99));
                default: value = 14'($urandom_range(0, 9999));
            endcase
            run($urandom_range(1, 40), 40);
            if ($urandom_range(0, 14) == 0) begin
                assert_reset();
                cyc(1'b1);
                arst = 1'b0;
            end
        end
        run(20, 50);

        @(negedge clk);
        #1;
        chk("queue_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
